// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control, PC select (inc/branch/rel/call/ret); CALL_STACK_EN adds a 4-deep return stack.
// Latency: control inputs sampled at an edge show on prog_counter after that edge; lut_addr is combinational.
// Backpressure: stall holds the PC and drops all other control for that cycle while cycle_count keeps running.
module pc_sequencer #(
    parameter int D          = 10,
    parameter int LUT_AW     = 4,
    parameter int START_ADDR = 0,
    parameter int CYC_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              halt,
    input  logic              branch_taken,
    input  logic [LUT_AW-1:0] br_idx,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [D-1:0]      lut_target,
    input  logic              rel_jump,
    input  logic [7:0]        rel_offset,
    input  logic              call,
    input  logic              ret,
    output logic [D-1:0]      prog_counter,
    output logic              busy,
    output logic              done,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              stack_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [D-1:0] START_PC = D'(START_ADDR);

    state_t           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [D-1:0]     pc_inc;
    logic [D-1:0]     pc_rel;
    logic [D-1:0]     off_ext;

`ifdef CALL_STACK_EN
    logic [D-1:0]     stack_q [4];
    logic [D-1:0]     stack_d [4];
    logic [2:0]       sp_q, sp_d;
    logic [2:0]       sp_m1;
    logic             err_q, err_d;
`endif

    assign lut_addr = br_idx;
    assign off_ext  = D'($signed(rel_offset));
    assign pc_inc   = pc_q + D'(1);
    assign pc_rel   = pc_q + off_ext;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef CALL_STACK_EN
        err_d   = err_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        sp_m1   = sp_q - 3'd1;
`endif
        case (state_q)
            S_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
                if (!stall) begin
                    if (halt) begin
                        state_d = S_DONE;
                    end
`ifdef CALL_STACK_EN
                    else if (call) begin
                        pc_d = lut_target;
                        if (sp_q == 3'd4) begin
                            err_d = 1'b1;
                        end else begin
                            stack_d[sp_q[1:0]] = pc_inc;
                            sp_d               = sp_q + 3'd1;
                        end
                    end else if (ret) begin
                        if (sp_q == 3'd0) begin
                            pc_d  = pc_inc;
                            err_d = 1'b1;
                        end else begin
                            pc_d = stack_q[sp_m1[1:0]];
                            sp_d = sp_m1;
                        end
                    end
`else
                    else if (call) begin
                        pc_d = lut_target;
                    end else if (ret) begin
                        pc_d = pc_inc;
                    end
`endif
                    else if (branch_taken) begin
                        pc_d = lut_target;
                    end else if (rel_jump) begin
                        pc_d = pc_rel;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                // IDLE and DONE share restart semantics
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
`ifdef CALL_STACK_EN
                    err_d   = 1'b0;
                    sp_d    = 3'd0;
`endif
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CALL_STACK_EN
            err_q   <= 1'b0;
            sp_q    <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CALL_STACK_EN
            err_q   <= err_d;
            sp_q    <= sp_d;
`endif
        end
`ifdef CALL_STACK_EN
        stack_q <= stack_d;
`endif
    end

    assign prog_counter = pc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cycle_count  = cnt_q;
`ifdef CALL_STACK_EN
    assign stack_err    = err_q;
`else
    assign stack_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, then random stimulus against a queue-based reference model.
module tb_pc_sequencer;

    localparam int D     = 10;
    localparam int PCM   = 1 << D;
    localparam int CMAX  = (1 << 16) - 1;
`ifdef CALL_STACK_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, stall, halt, branch_taken, rel_jump, call, ret;
    logic [3:0]   br_idx, lut_addr;
    logic [D-1:0] lut_target;
    logic [7:0]   rel_offset;
    logic [D-1:0] prog_counter;
    logic         busy, done, stack_err;
    logic [15:0]  cycle_count;

    int lut [16];
    assign lut_target = D'(lut[lut_addr]);

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .br_idx(br_idx), .lut_addr(lut_addr),
        .lut_target(lut_target), .rel_jump(rel_jump), .rel_offset(rel_offset),
        .call(call), .ret(ret), .prog_counter(prog_counter), .busy(busy),
        .done(done), .cycle_count(cycle_count), .stack_err(stack_err)
    );

    typedef struct packed {
        bit       reset, start, stall, halt, br, rj, call, ret;
        bit [3:0] idx;
        bit [7:0] off;
    } in_t;

    typedef struct {
        in_t in;
        int  pc;
        bit  busy;
        bit  done;
        int  cnt;
        bit  err;
    } row_t;

    row_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference model: mode 0=idle 1=run 2=done
    int   m_mode, m_pc, m_cnt;
    bit   m_err;
    int   m_stack[$];

    function automatic in_t mk(bit rs, bit st, bit sl, bit hl, bit br, bit rj,
                               bit ca, bit rt, int idx, int off);
        in_t v;
        v.reset = rs; v.start = st; v.stall = sl; v.halt = hl;
        v.br = br; v.rj = rj; v.call = ca; v.ret = rt;
        v.idx = 4'(idx); v.off = 8'(off);
        return v;
    endfunction

    function automatic void add(in_t v, int pc, bit b, bit d, int c, bit e);
        row_t r;
        r.in = v; r.pc = pc; r.busy = b; r.done = d; r.cnt = c; r.err = e;
        tbl.push_back(r);
    endfunction

    function automatic void model_step(in_t v);
        int o;
        if (v.reset) begin
            m_mode = 0; m_pc = 0; m_cnt = 0; m_err = 0; m_stack.delete();
        end else if (m_mode != 1) begin
            if (v.start) begin
                m_mode = 1; m_pc = 0; m_cnt = 0; m_err = 0; m_stack.delete();
            end
        end else begin
            if (m_cnt < CMAX) m_cnt++;
            if (!v.stall) begin
                if (v.halt) m_mode = 2;
                else if (v.call) begin
                    if (CS) begin
                        if (m_stack.size() == 4) m_err = 1;
                        else m_stack.push_back((m_pc + 1) % PCM);
                    end
                    m_pc = lut[v.idx];
                end else if (v.ret) begin
                    if (CS && m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else begin
                        if (CS) m_err = 1;
                        m_pc = (m_pc + 1) % PCM;
                    end
                end else if (v.br) m_pc = lut[v.idx];
                else if (v.rj) begin
                    o = int'($signed(v.off));
                    m_pc = ((m_pc + o) % PCM + PCM) % PCM;
                end else m_pc = (m_pc + 1) % PCM;
            end
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // drive away from the edge, check the combinational LUT index, then clock once
    task automatic tick(in_t v);
        reset = v.reset; start = v.start; stall = v.stall; halt = v.halt;
        branch_taken = v.br; rel_jump = v.rj; call = v.call; ret = v.ret;
        br_idx = v.idx; rel_offset = v.off;
        #1;
        check("lut_addr", 32'(lut_addr), 32'(v.idx));
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t R, S, N, v;
        for (int i = 0; i < 16; i++) lut[i] = (i * 67 + 5) % PCM;
        lut[1] = 11;  lut[2] = 41;  lut[3] = 57;  lut[5] = 1000; lut[6] = 10;
        lut[7] = 100; lut[8] = 200; lut[9] = 300; lut[10] = 400; lut[11] = 500;
        lut[13] = 1023;

        R = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        S = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        N = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // sequential run from start
        add(R, 0, 0, 0, 0, 0);
        add(S, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(N, i, 1, 0, i, 0);
        // absolute branch at PC=3
        add(R, 0, 0, 0, 0, 0);
        add(S, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) add(N, i, 1, 0, i, 0);
        add(mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 0), 41, 1, 0, 4, 0);
        add(N, 42, 1, 0, 5, 0);
        // relative jumps with wrap, stall, halt, restart from DONE
        add(R, 0, 0, 0, 0, 0);
        add(S, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add(N, i, 1, 0, i, 0);
        add(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, -5), 1023, 1, 0, 5, 0);
        add(N, 0, 1, 0, 6, 0);
        add(mk(0, 0, 0, 0, 1, 0, 0, 0, 5, 0), 1000, 1, 0, 7, 0);
        add(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 20), 1020, 1, 0, 8, 0);
        for (int k = 0; k < 3; k++)
            add(mk(0, 0, 1, 0, 1, 0, 0, 0, 2, 0), 1020, 1, 0, 9 + k, 0);
        add(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1020, 0, 1, 12, 0);
        add(N, 1020, 0, 1, 12, 0);
        add(S, 0, 1, 0, 0, 0);
        add(S, 1, 1, 0, 1, 0);
        // reset mid-run at PC=57, then branch beats relative jump
        add(mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 0), 57, 1, 0, 2, 0);
        add(mk(1, 0, 0, 0, 1, 0, 0, 0, 3, 0), 0, 0, 0, 0, 0);
        add(N, 0, 0, 0, 0, 0);
        add(S, 0, 1, 0, 0, 0);
        add(mk(0, 0, 0, 0, 1, 1, 0, 0, 2, 20), 41, 1, 0, 1, 0);
        // call / ret from PC=10
        add(R, 0, 0, 0, 0, 0);
        add(S, 0, 1, 0, 0, 0);
        add(mk(0, 0, 0, 0, 1, 0, 0, 0, 6, 0), 10, 1, 0, 1, 0);
        if (CS) begin
            for (int k = 0; k < 5; k++)
                add(mk(0, 0, 0, 0, 0, 0, 1, 0, 7 + k, 0), 100 * (k + 1), 1, 0, 2 + k, k == 4);
            add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 301, 1, 0, 7, 1);
            add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 201, 1, 0, 8, 1);
            add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 101, 1, 0, 9, 1);
            add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 11, 1, 0, 10, 1);
            add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 12, 1, 0, 11, 1);
        end else begin
            add(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 11, 1, 0, 2, 0);
            add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 12, 1, 0, 3, 0);
        end

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            tick(tbl[i].in);
            check("tbl_pc", 32'(prog_counter), 32'(tbl[i].pc));
            check("tbl_busy", 32'(busy), 32'(tbl[i].busy));
            check("tbl_done", 32'(done), 32'(tbl[i].done));
            check("tbl_cycle_count", 32'(cycle_count), 32'(tbl[i].cnt));
            check("tbl_stack_err", 32'(stack_err), 32'(tbl[i].err));
        end

        for (int n = 0; n < 3000; n++) begin
            v.reset = ($urandom_range(63) == 0);
            v.start = ($urandom_range(7) == 0);
            v.stall = ($urandom_range(7) == 0);
            v.halt  = ($urandom_range(31) == 0);
            v.br    = ($urandom_range(3) == 0);
            v.rj    = ($urandom_range(3) == 0);
            v.call  = ($urandom_range(7) == 0);
            v.ret   = ($urandom_range(6) == 0);
            v.idx   = 4'($urandom_range(15));
            v.off   = 8'($urandom_range(255));
            tick(v);
            check("rnd_pc", 32'(prog_counter), 32'(m_pc));
            check("rnd_busy", 32'(busy), 32'(m_mode == 1));
            check("rnd_done", 32'(done), 32'(m_mode == 2));
            check("rnd_cycle_count", 32'(cycle_count), 32'(m_cnt));
            check("rnd_stack_err", 32'(stack_err), 32'(m_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
